bin2bcd_6digit: RTL and testbench
=================================

Name: bin2bcd_6digit

Overview:
- Sequential binary-to-BCD converter that feeds the six-digit 7-segment scan driver.
- Takes an unsigned binary value from the CPU or debug logic. Runs a shift-add-3 conversion (double dabble), one bit per clock.
- Presents six registered decimal digits, one per display data input. Digit 0 is the ones digit and drives DIG1.
- Digit outputs change only on conversion completion, so the display never shows partial results.

Parameters:
- WIDTH, 20, binary input width and number of shift iterations. Legal range 1..20.
- MAX_VAL, 999999, saturation threshold. Largest value six digits can show.

Ports:
- clk  in  1  system clock (50 MHz)
- rst_n  in  1  synchronous reset, active-low
- value  in  WIDTH  unsigned binary operand, sampled on accepted start
- start  in  1  conversion request, level-sampled
- busy  out  1  high while a conversion is in progress
- done  out  1  single-cycle pulse; digits are valid and updated
- ovf  out  1  registered; value at last accepted start exceeded MAX_VAL
- digit0..digit5  out  8 each  BCD digit in bits [3:0]; bits [7:4] = 0 unless the optional feature is enabled

Behaviour:
- Reset: rst_n sampled low at a clk edge (synchronous) forces the following:
  - state IDLE
  - busy=0, done=0, ovf=0
  - all digits 8'h00
  - shift register and iteration counter cleared
- Reset mid-conversion aborts it; no done is produced.
- States:
  - IDLE: busy=0. start=1 at edge E0 is accepted.
    - If value > MAX_VAL: load MAX_VAL into the shift register, set the ovf_pending flag.
    - Otherwise: load value.
    - Clear BCD accumulator (24 bits) and counter; go to CONV.
  - CONV: busy=1. Each edge performs one iteration:
    - every BCD nibble >= 5 gets +3, combinationally;
    - then {bcd, bin} shifts left by 1;
    - counter increments.
  - Final iteration (counter = WIDTH-1, edge E_WIDTH):
    - digit0..5 are loaded with the shifted result;
    - ovf <= ovf_pending; done <= 1;
    - state returns to IDLE.
- Latency: done is high in the cycle after edge E_WIDTH, i.e. 20 cycles after the start edge at default.
- Throughput: one conversion per WIDTH+1 cycles if start is held high. The start asserted while done=1 is accepted, because state is already IDLE.
- start while busy=1 is ignored. It is not queued.
- value changes after acceptance have no effect.
- Digits and ovf hold their last values between conversions. Before the first conversion after reset they read 0.
- Nibble add-3 works on 4-bit unsigned arithmetic. No nibble ever exceeds 9 after the final shift, because the input is capped to MAX_VAL.
- WIDTH < 20: the input is zero-extended, and the saturation compare is done at 20 bits.

Optional Feature:
- Macro: BIN2BCD_LEAD_BLANK_EN.
- Defined:
  - For every digit k in 5..1 such that digits k..5 are all zero, bit 4 of digit k is set to 1 (blank flag). Downstream logic uses it to blank the digit.
  - digit0 is never blanked.
  - Flags are computed at the final iteration and registered together with the digits.
- Undefined: bits [7:4] are constant 0 and no blank logic is synthesized.

Decomposition:
- Shared package disp_pkg:
  - NUM_DIGITS=6;
  - BCD_W=4;
  - DIGIT_W=8;
  - MAX_VAL default;
  - state enum (IDLE, CONV);
  - BLANK_BIT=4.
- One natural sub-module, bcd_add3, a combinational nibble corrector:
  - input nibble, output nibble+3 if >= 5, else unchanged;
  - instantiated six times.

Test Plan:
- Reset: rst_n=0 for 2 cycles during CONV -> busy=0, done=0, ovf=0, all digits 0; no done ever follows.
- value=123456, start pulse -> done 20 cycles later; digit5..0 = 1,2,3,4,5,6; ovf=0; busy high for exactly 20 cycles.
- value=0, then value=999999 back-to-back with start held high -> first done gives all zeros. Second conversion is accepted on the done cycle; its done comes 21 cycles after the first and gives all 9s.
- value=20'hFFFFF (1048575) -> digits 9,9,9,9,9,9, ovf=1. A following value=42 clears ovf=0 with digits 0,0,0,0,4,2.
- start pulsed again mid-conversion with value=7 -> ignored. Result is the first operand and only one done pulse occurs.
- With BIN2BCD_LEAD_BLANK_EN, value=305 -> digit5..3 = 8'h10, digit2=8'h03, digit1=8'h00, digit0=8'h05. With value=0, only digit0 is unblanked (8'h00).

Source files
------------

// File: rtl/disp_pkg.sv
// Shared definitions for the six-digit display path.
// Digit geometry, saturation limit, converter state encoding.
package disp_pkg;

    localparam int NUM_DIGITS   = 6;
    localparam int BCD_W        = 4;
    localparam int DIGIT_W      = 8;
    localparam int BLANK_BIT    = 4;
    localparam int SAT_W        = 20;
    localparam int CNT_W        = 5;
    localparam int MAX_VAL_DFLT = 999999;

    typedef enum logic {
        IDLE = 1'b0,
        CONV = 1'b1
    } state_t;

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble nibble corrector: adds 3 when nibble >= 5.
// Ports: nibble (in, 4b), fixed (out, 4b corrected nibble).
module bcd_add3 (
    input  logic [3:0] nibble,
    output logic [3:0] fixed
);

    assign fixed = (nibble >= 4'd5) ? nibble + 4'd3 : nibble;

endmodule

// File: rtl/bin2bcd_6digit.sv
// Sequential binary-to-BCD converter (one bit per clock) for the
// six-digit scan driver; saturates at MAX_VAL and flags ovf.
// Ports: clk, rst_n (sync, active-low), value[WIDTH], start,
//        busy, done (1-cycle pulse), ovf, digit0..digit5 [8].
// Option: BIN2BCD_LEAD_BLANK_EN sets bit 4 on leading-zero digits.
module bin2bcd_6digit
    import disp_pkg::*;
#(
    parameter int WIDTH   = 20,
    parameter int MAX_VAL = MAX_VAL_DFLT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [WIDTH-1:0]   value,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic               ovf,
    output logic [DIGIT_W-1:0] digit0,
    output logic [DIGIT_W-1:0] digit1,
    output logic [DIGIT_W-1:0] digit2,
    output logic [DIGIT_W-1:0] digit3,
    output logic [DIGIT_W-1:0] digit4,
    output logic [DIGIT_W-1:0] digit5
);

    localparam int BCD_TOT = NUM_DIGITS * BCD_W;
    localparam logic [SAT_W-1:0] MAX_L = SAT_W'(MAX_VAL);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

    state_t               state_q;
    state_t               state_d;
    logic [WIDTH-1:0]     bin_q;
    logic [BCD_TOT-1:0]   bcd_q;
    logic [CNT_W-1:0]     cnt_q;
    logic                 ovf_pend_q;
    logic                 ovf_q;
    logic                 done_q;
    logic [DIGIT_W-1:0]   dig_q   [NUM_DIGITS];
    logic [DIGIT_W-1:0]   dig_nxt [NUM_DIGITS];

    logic                 accept;
    logic                 last_iter;
    logic [SAT_W-1:0]     value_ext;
    logic                 sat;
    logic [WIDTH-1:0]     load_val;
    logic [BCD_TOT-1:0]   bcd_fix;
    logic [BCD_TOT-1:0]   bcd_shift;

    // Saturation compare is always done at full 20-bit width.
    assign value_ext = SAT_W'(value);
    assign sat       = value_ext > MAX_L;
    assign load_val  = sat ? MAX_L[WIDTH-1:0] : value;

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_add3
        bcd_add3 u_add3 (
            .nibble (bcd_q[g*BCD_W +: BCD_W]),
            .fixed  (bcd_fix[g*BCD_W +: BCD_W])
        );
    end

    // Correct first, then shift {bcd, bin} left by one.
    assign bcd_shift = {bcd_fix[BCD_TOT-2:0], bin_q[WIDTH-1]};

    always_comb begin
        state_d   = state_q;
        busy      = 1'b0;
        accept    = 1'b0;
        last_iter = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = CONV;
                end
            end
            CONV: begin
                busy = 1'b1;
                if (cnt_q == LAST) begin
                    last_iter = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef BIN2BCD_LEAD_BLANK_EN
    logic lead_zero;

    // A digit is blank when it and every more significant digit is 0.
    always_comb begin
        lead_zero = 1'b1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            dig_nxt[k] = DIGIT_W'(bcd_shift[k*BCD_W +: BCD_W]);
        end
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            lead_zero = lead_zero &
                (bcd_shift[k*BCD_W +: BCD_W] == '0);
            dig_nxt[k][BLANK_BIT] = lead_zero;
        end
    end
`else
    always_comb begin
        for (int k = 0; k < NUM_DIGITS; k++) begin
            dig_nxt[k] = DIGIT_W'(bcd_shift[k*BCD_W +: BCD_W]);
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bin_q      <= '0;
            bcd_q      <= '0;
            cnt_q      <= '0;
            ovf_pend_q <= 1'b0;
            ovf_q      <= 1'b0;
            done_q     <= 1'b0;
            for (int k = 0; k < NUM_DIGITS; k++) begin
                dig_q[k] <= '0;
            end
        end else begin
            done_q <= 1'b0;
            if (accept) begin
                bin_q      <= load_val;
                bcd_q      <= '0;
                cnt_q      <= '0;
                ovf_pend_q <= sat;
            end else if (busy) begin
                bcd_q <= bcd_shift;
                bin_q <= bin_q << 1;
                cnt_q <= cnt_q + ONE;
                if (last_iter) begin
                    for (int k = 0; k < NUM_DIGITS; k++) begin
                        dig_q[k] <= dig_nxt[k];
                    end
                    ovf_q  <= ovf_pend_q;
                    done_q <= 1'b1;
                end
            end
        end
    end

    assign done   = done_q;
    assign ovf    = ovf_q;
    assign digit0 = dig_q[0];
    assign digit1 = dig_q[1];
    assign digit2 = dig_q[2];
    assign digit3 = dig_q[3];
    assign digit4 = dig_q[4];
    assign digit5 = dig_q[5];

endmodule

// File: tb/tb_bin2bcd_6digit.sv
// Self-checking bench for bin2bcd_6digit: directed cases plus
// random operands against an arithmetic decimal model.
module tb_bin2bcd_6digit;

    logic        clk;
    logic        rst_n;
    logic [19:0] value;
    logic        start;
    logic        busy;
    logic        done;
    logic        ovf;
    logic [7:0]  digit0, digit1, digit2;
    logic [7:0]  digit3, digit4, digit5;

    int errors = 0;
    int checks = 0;

    bin2bcd_6digit dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .value  (value),
        .start  (start),
        .busy   (busy),
        .done   (done),
        .ovf    (ovf),
        .digit0 (digit0),
        .digit1 (digit1),
        .digit2 (digit2),
        .digit3 (digit3),
        .digit4 (digit4),
        .digit5 (digit5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] get_dig(input int k);
        case (k)
            0: return digit0;
            1: return digit1;
            2: return digit2;
            3: return digit3;
            4: return digit4;
            default: return digit5;
        endcase
    endfunction

    // Decimal digit k of min(v, 999999), with optional blank flag.
    function automatic logic [7:0] exp_dig(input int unsigned v,
                                           input int k);
        int unsigned s;
        int unsigned p;
        int unsigned d;
        logic [7:0]  e;
        s = (v > 999999) ? 999999 : v;
        p = 1;
        for (int i = 0; i < k; i++) p = p * 10;
        d = (s / p) % 10;
        e = 8'(d);
`ifdef BIN2BCD_LEAD_BLANK_EN
        if (k > 0 && s < p) e[4] = 1'b1;
`endif
        return e;
    endfunction

    task automatic check_result(input int unsigned v);
        for (int k = 0; k < 6; k++) begin
            check($sformatf("digit%0d v=%0d", k, v),
                  32'(get_dig(k)), 32'(exp_dig(v, k)));
        end
        check($sformatf("ovf v=%0d", v), 32'(ovf),
              32'(v > 999999));
    endtask

    // Wait for done after an accepted start; sampled #1 after edges.
    task automatic wait_done(input int glitch_at,
                             output int cyc, output int bcnt);
        cyc  = 0;
        bcnt = 0;
        while (!done && cyc < 100) begin
            bcnt += int'(busy);
            if (cyc == glitch_at) begin
                start = 1'b1;
                value = 20'd7;
            end else if (cyc == glitch_at + 1) begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
    endtask

    task automatic convert(input logic [19:0] v, input int glitch_at);
        int cyc, bcnt;
        @(negedge clk);
        value = v;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        value = ~v;
        wait_done(glitch_at, cyc, bcnt);
        check($sformatf("latency v=%0d", v), 32'(cyc), 32'd20);
        check($sformatf("busy_len v=%0d", v), 32'(bcnt), 32'd20);
        check_result(int'(v));
        @(posedge clk); #1;
        check($sformatf("done_pulse v=%0d", v), 32'(done), 32'd0);
    endtask

    initial begin
        int cyc, bcnt, gap;
        bit saw_done;
        rst_n = 1'b0;
        start = 1'b0;
        value = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst busy", 32'(busy), 0);
        check("rst done", 32'(done), 0);
        check_result(0);
        @(negedge clk);
        rst_n = 1'b1;

        convert(20'd123456, -10);
        convert(20'hFFFFF, -10);
        convert(20'd42, -10);
        convert(20'd999999, -10);
        convert(20'd1000000, -10);
        convert(20'd305, -10);
        convert(20'd0, -10);
        convert(20'd654321, 5);

        // Back-to-back with start held high.
        @(negedge clk);
        value = 20'd0;
        start = 1'b1;
        @(posedge clk); #1;
        value = 20'd999999;
        cyc = 0;
        while (!done && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("b2b first latency", 32'(cyc), 32'd20);
        check_result(0);
        gap = 0;
        @(posedge clk); #1;
        gap++;
        start = 1'b0;
        while (!done && gap < 100) begin
            @(posedge clk); #1;
            gap++;
        end
        check("b2b gap", 32'(gap), 32'd21);
        check_result(999999);

        // Reset during a conversion aborts it.
        @(negedge clk);
        value = 20'd777777;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("midrst busy", 32'(busy), 0);
        check("midrst done", 32'(done), 0);
        check_result(0);
        @(negedge clk);
        rst_n = 1'b1;
        saw_done = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (done) saw_done = 1'b1;
        end
        check("midrst no done", 32'(saw_done), 0);
        check("midrst idle", 32'(busy), 0);

        for (int i = 0; i < 30; i++) begin
            logic [19:0] r;
            r = (i % 3 == 0) ? 20'($urandom_range(0, 20'hFFFFF))
                             : 20'($urandom_range(0, 999999));
            convert(r, (i % 5 == 0) ? 3 : -10);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
